// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and constants for the mux_4_1 select sequencer.
package mux_sel_sequencer_pkg;

  localparam int unsigned N_INPUTS = 4;
  localparam int unsigned SEL_W    = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StRun  = RUN,
    StDone = DONE
  } state_e;

  function automatic logic [SEL_W-1:0] first_idx(input bit msb_first);
    return msb_first ? SEL_W'(N_INPUTS - 1) : '0;
  endfunction

  function automatic logic [SEL_W-1:0] last_idx(input bit msb_first);
    return msb_first ? '0 : SEL_W'(N_INPUTS - 1);
  endfunction

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Handshake and selector-drive bundle between a word source and the sequencer.
interface mux_sel_sequencer_if;
  import mux_sel_sequencer_pkg::*;

  logic [N_INPUTS-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic                abort;
  logic [N_INPUTS-1:0] data_q;
  logic [SEL_W-1:0]    sel;
  logic                step_valid;
  logic                last;
  logic                busy;
  logic                done;

  modport master (
    output in_data, in_valid, abort,
    input  in_ready, data_q, sel, step_valid, last, busy, done
  );

  modport slave (
    input  in_data, in_valid, abort,
    output in_ready, data_q, sel, step_valid, last, busy, done
  );

endinterface

// File: rtl/mux_4_1.sv
// Plain combinational 4:1 selector driven by the sequencer.
module mux_4_1 (
  input  logic [3:0] d,
  input  logic [1:0] sel,
  output logic       y
);

  assign y = d[sel];

endmodule

// File: rtl/mux_sel_sequencer_step_timer.sv
// Per-step dwell counter: tick marks the last cycle of a select step.
module step_timer #(
  parameter int unsigned CYCLES_PER_STEP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (CYCLES_PER_STEP > 1) ? $clog2(CYCLES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CYCLES_PER_STEP - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == TERM);

  // Hold at terminal until cleared; the counter never wraps by itself.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Captures a 4-bit word and walks the mux select across it, one index per step period.
module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter int unsigned CYCLES_PER_STEP = 1,
  parameter bit          MSB_FIRST       = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_sel_sequencer_if.slave   bus
);

  localparam logic [SEL_W-1:0] FIRST_IDX = first_idx(MSB_FIRST);
  localparam logic [SEL_W-1:0] LAST_IDX  = last_idx(MSB_FIRST);

  state_e              state_q, state_d;
  logic [N_INPUTS-1:0] data_q, data_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                tick;
  logic                timer_clear;
  logic                timer_enable;

  assign timer_enable = (state_q == StRun);
  assign timer_clear  = (state_q != StRun) || tick || bus.abort;

  step_timer #(
    .CYCLES_PER_STEP (CYCLES_PER_STEP)
  ) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          sel_d   = FIRST_IDX;
          state_d = StRun;
        end
      end
      StRun: begin
        // Abort outranks a coinciding terminal count, so no done is raised.
        if (bus.abort) begin
          state_d = StIdle;
        end else if (tick) begin
          if (sel_q == LAST_IDX) begin
            state_d = StDone;
          end else begin
            sel_d = MSB_FIRST ? sel_q - SEL_W'(1) : sel_q + SEL_W'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.step_valid = (state_q == StRun);
  assign bus.last       = (state_q == StRun) && (sel_q == LAST_IDX);
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.data_q     = data_q;
  assign bus.sel        = sel_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench: three sequencer configurations each feeding a mux_4_1.
module tb_mux_sel_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   ndone;
  logic [11:0] ytab;

  mux_sel_sequencer_if ia ();
  mux_sel_sequencer_if ib ();
  mux_sel_sequencer_if ic ();
  logic ya, yb, yc;

  mux_sel_sequencer #(.CYCLES_PER_STEP(1), .MSB_FIRST(1'b0)) dut_a (
    .clk (clk), .rst (rst), .bus (ia)
  );
  mux_sel_sequencer #(.CYCLES_PER_STEP(3), .MSB_FIRST(1'b0)) dut_b (
    .clk (clk), .rst (rst), .bus (ib)
  );
  mux_sel_sequencer #(.CYCLES_PER_STEP(1), .MSB_FIRST(1'b1)) dut_c (
    .clk (clk), .rst (rst), .bus (ic)
  );

  mux_4_1 mux_a (.d (ia.data_q), .sel (ia.sel), .y (ya));
  mux_4_1 mux_b (.d (ib.data_q), .sel (ib.sel), .y (yb));
  mux_4_1 mux_c (.d (ic.data_q), .sel (ic.sel), .y (yc));

  // Status packing: {sel, mux_out, step_valid, last, done, in_ready, busy}
  logic [7:0] st_a, st_b, st_c;
  assign st_a = {ia.sel, ya, ia.step_valid, ia.last, ia.done, ia.in_ready, ia.busy};
  assign st_b = {ib.sel, yb, ib.step_valid, ib.last, ib.done, ib.in_ready, ib.busy};
  assign st_c = {ic.sel, yc, ic.step_valid, ic.last, ic.done, ic.in_ready, ic.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] st(input logic [1:0] s, input logic y, input logic sv,
                                    input logic lst, input logic dn, input logic rdy,
                                    input logic bsy);
    return {s, y, sv, lst, dn, rdy, bsy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ndone  = 0;
    ytab   = 12'b000111111000;
    rst = 1'b1;
    ia.in_data = '0; ia.in_valid = 1'b0; ia.abort = 1'b0;
    ib.in_data = '0; ib.in_valid = 1'b0; ib.abort = 1'b0;
    ic.in_data = '0; ic.in_valid = 1'b0; ic.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", st_a, st(2'd0, 1'b0, 0, 0, 0, 1, 0));
    chk("rst_a_data", ia.data_q, 4'h0);
    chk("rst_b", st_b, st(2'd0, 1'b0, 0, 0, 0, 1, 0));
    chk("rst_c", st_c, st(2'd0, 1'b0, 0, 0, 0, 1, 0));
    rst = 1'b0;
    step();

    // Default params, word 1010
    ia.in_data = 4'b1010; ia.in_valid = 1'b1;
    step();
    ia.in_valid = 1'b0;
    chk("a_s0", st_a, st(2'd0, 1'b0, 1, 0, 0, 0, 1));
    chk("a_data", ia.data_q, 4'hA);
    step(); chk("a_s1", st_a, st(2'd1, 1'b1, 1, 0, 0, 0, 1));
    step(); chk("a_s2", st_a, st(2'd2, 1'b0, 1, 0, 0, 0, 1));
    step(); chk("a_s3", st_a, st(2'd3, 1'b1, 1, 1, 0, 0, 1));
    step(); chk("a_done", st_a, st(2'd3, 1'b1, 0, 0, 1, 0, 1));
    step(); chk("a_idle", st_a, st(2'd3, 1'b1, 0, 0, 0, 1, 0));

    // CYCLES_PER_STEP=3, word 0110
    ib.in_data = 4'b0110; ib.in_valid = 1'b1;
    step();
    ib.in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("b_run%0d", i), st_b,
          st(2'(i / 3), ytab[i], 1, (i >= 9), 0, 0, 1));
      step();
    end
    chk("b_done", st_b, st(2'd3, 1'b0, 0, 0, 1, 0, 1));
    step(); chk("b_idle", st_b, st(2'd3, 1'b0, 0, 0, 0, 1, 0));

    // MSB_FIRST=1, word 1000
    ic.in_data = 4'b1000; ic.in_valid = 1'b1;
    step();
    ic.in_valid = 1'b0;
    chk("c_s3", st_c, st(2'd3, 1'b1, 1, 0, 0, 0, 1));
    step(); chk("c_s2", st_c, st(2'd2, 1'b0, 1, 0, 0, 0, 1));
    step(); chk("c_s1", st_c, st(2'd1, 1'b0, 1, 0, 0, 0, 1));
    step(); chk("c_s0", st_c, st(2'd0, 1'b0, 1, 1, 0, 0, 1));
    step(); chk("c_done", st_c, st(2'd0, 1'b0, 0, 0, 1, 0, 1));
    step(); chk("c_idle", st_c, st(2'd0, 1'b0, 0, 0, 0, 1, 0));

    // in_valid held high: A then 5, second accept 6 cycles after the first
    ia.in_data = 4'hA; ia.in_valid = 1'b1;
    step();
    ia.in_data = 4'h5;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("h_rdy%0d", i), ia.in_ready, 1'b0);
      chk($sformatf("h_data%0d", i), ia.data_q, 4'hA);
      step();
    end
    chk("h_idle", st_a, st(2'd3, 1'b1, 0, 0, 0, 1, 0));
    step();
    ia.in_valid = 1'b0;
    chk("h_data2", ia.data_q, 4'h5);
    chk("h_s0", st_a, st(2'd0, 1'b1, 1, 0, 0, 0, 1));
    step(); step(); step();
    chk("h_s3", st_a, st(2'd3, 1'b0, 1, 1, 0, 0, 1));
    step(); chk("h_done", st_a, st(2'd3, 1'b0, 0, 0, 1, 0, 1));
    step();

    // Abort while sel=2, then a fresh word
    ia.in_data = 4'h3; ia.in_valid = 1'b1;
    step();
    ia.in_valid = 1'b0;
    step(); step();
    chk("ab_s2", st_a, st(2'd2, 1'b0, 1, 0, 0, 0, 1));
    ia.abort = 1'b1;
    step();
    ia.abort = 1'b0;
    chk("ab_idle", st_a, st(2'd2, 1'b0, 0, 0, 0, 1, 0));
    chk("ab_data", ia.data_q, 4'h3);
    step(); chk("ab_hold", st_a, st(2'd2, 1'b0, 0, 0, 0, 1, 0));
    ia.in_data = 4'hF; ia.in_valid = 1'b1;
    step();
    ia.in_valid = 1'b0;
    chk("f_s0", st_a, st(2'd0, 1'b1, 1, 0, 0, 0, 1));
    step(); step(); step();
    chk("f_s3", st_a, st(2'd3, 1'b1, 1, 1, 0, 0, 1));
    step(); chk("f_done", st_a, st(2'd3, 1'b1, 0, 0, 1, 0, 1));
    step();

    // Abort coinciding with the final terminal count: no done
    ia.in_data = 4'h9; ia.in_valid = 1'b1;
    step();
    ia.in_valid = 1'b0;
    step(); step(); step();
    chk("at_s3", st_a, st(2'd3, 1'b1, 1, 1, 0, 0, 1));
    ia.abort = 1'b1;
    step();
    ia.abort = 1'b0;
    chk("at_idle", st_a, st(2'd3, 1'b1, 0, 0, 0, 1, 0));

    // Asynchronous reset mid-RUN
    ia.in_data = 4'hC; ia.in_valid = 1'b1;
    step();
    ia.in_valid = 1'b0;
    step();
    chk("r_s1", st_a, st(2'd1, 1'b0, 1, 0, 0, 0, 1));
    #3;
    rst = 1'b1;
    #1;
    chk("r_async", st_a, st(2'd0, 1'b0, 0, 0, 0, 1, 0));
    chk("r_data", ia.data_q, 4'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ia.done) ndone++;
      step();
    end
    chk("r_nodone", ndone, 0);
    chk("r_idle", st_a, st(2'd0, 1'b0, 0, 0, 0, 1, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
